// File: rtl/rank_order_scheduler_pkg.sv
// rtl/rank_order_scheduler_pkg.sv - shared frame constants and scheduler state type
package rank_order_pkg;

    localparam int IMAGE_SIZE             = 5;
    localparam int IMAGE_SIZE_BITS        = $clog2(IMAGE_SIZE);
    localparam int PIXEL_MAX_VALUE        = 10;
    localparam int PIXEL_BITS             = $clog2(PIXEL_MAX_VALUE);
    localparam int DEFAULT_SPIKE_GAP      = 2;
    localparam int DEFAULT_TIMEOUT_CYCLES = 256;

    typedef logic [PIXEL_BITS-1:0] pixel_t;
    typedef pixel_t [IMAGE_SIZE-1:0] image_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_SORT,
        EMIT,
        GAP
    } sched_state_t;

endpackage

// File: rtl/rank_order_scheduler_if.sv
// rtl/rank_order_scheduler_if.sv - image, sorter and spike signals of the scheduler
interface rank_order_scheduler_if;
    import rank_order_pkg::*;

    image_t                     img_in;
    logic                       img_valid;
    logic                       img_ready;
    image_t                     sort_image;
    logic                       sort_start;
    logic                       sort_done;
    image_t                     sort_indexes;
    logic                       spike_valid;
    logic                       spike_ready;
    logic [IMAGE_SIZE_BITS-1:0] spike_addr;
    logic                       spike_last;
    logic                       frame_done;
    logic                       err_timeout;

    // slave is the scheduler side; master is the surrounding source/sorter/core
    modport slave (
        input  img_in, img_valid, sort_done, sort_indexes, spike_ready,
        output img_ready, sort_image, sort_start, spike_valid, spike_addr,
               spike_last, frame_done, err_timeout
    );

    modport master (
        output img_in, img_valid, sort_done, sort_indexes, spike_ready,
        input  img_ready, sort_image, sort_start, spike_valid, spike_addr,
               spike_last, frame_done, err_timeout
    );

endinterface

// File: rtl/rank_order_scheduler.sv
// rtl/rank_order_scheduler.sv - sequences image -> sorter -> rank-order spike stream
module rank_order_scheduler
    import rank_order_pkg::*;
#(
    parameter int SPIKE_GAP      = DEFAULT_SPIKE_GAP,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  CLK,
    input  logic                  RST,
    rank_order_scheduler_if.slave bus
);

    localparam int GAP_W    = (SPIKE_GAP > 0) ? $clog2(SPIKE_GAP + 1) : 1;
    localparam int GAP_LAST = (SPIKE_GAP > 0) ? SPIKE_GAP - 1 : 0;
    localparam int WD_W     = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int IDX_W    = IMAGE_SIZE_BITS + 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(IMAGE_SIZE - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_END  = GAP_W'(GAP_LAST);

    sched_state_t               state, state_n;
    logic [IDX_W-1:0]           idx, idx_n;
    logic [GAP_W-1:0]           gap_cnt, gap_n;
    logic [WD_W-1:0]            wd, wd_n;
    image_t                     idx_buf, buf_n;
    logic                       accept;
    logic                       frame_done_n;
    logic                       err_timeout_n;
    logic [IMAGE_SIZE_BITS-1:0] addr_n;

    always_comb begin
        state_n       = state;
        idx_n         = idx;
        gap_n         = gap_cnt;
        wd_n          = wd;
        buf_n         = idx_buf;
        accept        = 1'b0;
        frame_done_n  = 1'b0;
        err_timeout_n = 1'b0;

        case (state)
            IDLE: begin
                if (bus.img_valid) begin
                    accept  = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                wd_n    = '0;
                state_n = WAIT_SORT;
            end
            WAIT_SORT: begin
                if (wd != '1) begin
                    wd_n = wd + 1'b1;
                end
                // completion takes priority over a coincident watchdog expiry
                if (bus.sort_done) begin
                    buf_n   = bus.sort_indexes;
                    idx_n   = '0;
                    state_n = EMIT;
                end else if (wd == WD_LAST) begin
                    err_timeout_n = 1'b1;
                    state_n       = IDLE;
                end
            end
            EMIT: begin
                if (bus.spike_ready) begin
                    if (idx == IDX_LAST) begin
                        frame_done_n = 1'b1;
                        state_n      = IDLE;
                    end else begin
                        idx_n = idx + 1'b1;
                        if (SPIKE_GAP > 0) begin
                            gap_n   = '0;
                            state_n = GAP;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_END) begin
                    state_n = EMIT;
                end else begin
                    gap_n = gap_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        addr_n = buf_n[idx_n[IMAGE_SIZE_BITS-1:0]][IMAGE_SIZE_BITS-1:0];
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state           <= IDLE;
            idx             <= '0;
            gap_cnt         <= '0;
            wd              <= '0;
            idx_buf         <= '0;
            bus.sort_image  <= '0;
            bus.img_ready   <= 1'b1;
            bus.sort_start  <= 1'b0;
            bus.spike_valid <= 1'b0;
            bus.spike_addr  <= '0;
            bus.spike_last  <= 1'b0;
            bus.frame_done  <= 1'b0;
            bus.err_timeout <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            gap_cnt <= gap_n;
            wd      <= wd_n;
            idx_buf <= buf_n;
            if (accept) begin
                bus.sort_image <= bus.img_in;
            end
            bus.img_ready   <= (state_n == IDLE);
            bus.sort_start  <= (state_n == START);
            bus.spike_valid <= (state_n == EMIT);
            if (state_n == EMIT) begin
                bus.spike_addr <= addr_n;
            end
            bus.spike_last  <= (state_n == EMIT) && (idx_n == IDX_LAST);
            bus.frame_done  <= frame_done_n;
            bus.err_timeout <= err_timeout_n;
        end
    end

endmodule
